// File: rtl/fpu_to_int.sv
// Iterative float-to-int converter (sign, 6-bit exponent bias 31, 25-bit fraction).
// Define FPU2INT_ROUND_EN for round-to-nearest-even; default build truncates toward zero.
module fpu_to_int (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, SIGN, DONE} state_t;
  typedef enum logic [3:0] {
    ST_EXACT     = 4'd0,
    ST_INEXACT   = 4'd1,
    ST_OVERFLOW  = 4'd2,
    ST_UNDERFLOW = 4'd3
  } status_t;

`ifdef FPU2INT_ROUND_EN
  localparam bit         ROUND_EN      = 1'b1;
  localparam logic [5:0] UNDERFLOW_EXP = 6'd30;  // k = -1 still rounds up to 1
`else
  localparam bit         ROUND_EN      = 1'b0;
  localparam logic [5:0] UNDERFLOW_EXP = 6'd31;
`endif

  // Exponent at which the 26-bit significand is already an integer (k = 25).
  localparam logic [5:0] ALIGN_EXP = 6'd56;

  state_t      state;
  logic [31:0] op_reg;
  logic [30:0] mag;
  logic [5:0]  n;
  logic        shift_left;
  logic        guard;
  logic        sticky;

  logic        sign;
  logic [5:0]  exponent;
  logic [24:0] frac;
  logic        is_zero;
  logic        is_overflow;
  logic        is_min_int;
  logic        is_underflow;
  logic        shift_left_c;
  logic [5:0]  shift_amt;
  logic        inexact;
  logic        round_up;
  logic [30:0] mag_rnd;
  logic [31:0] result;

  assign sign     = op_reg[31];
  assign exponent = op_reg[30:25];
  assign frac     = op_reg[24:0];

  always_comb begin
    is_zero      = (exponent == 6'd0) && (frac == 25'd0);
    is_overflow  = (exponent >= 6'd62);
    is_min_int   = sign && (exponent == 6'd62) && (frac == 25'd0);
    is_underflow = (exponent < UNDERFLOW_EXP);
    shift_left_c = (exponent > ALIGN_EXP);
    shift_amt    = shift_left_c ? (exponent - ALIGN_EXP) : (ALIGN_EXP - exponent);
  end

  always_comb begin
    inexact  = guard | sticky;
    round_up = ROUND_EN & guard & (sticky | mag[0]);
    mag_rnd  = mag + {30'd0, round_up};
    result   = sign ? (32'd0 - {1'b0, mag_rnd}) : {1'b0, mag_rnd};
  end

  // NOTE: every register in this block uses <= so all updates see pre-edge values.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state      <= IDLE;
      op_reg     <= '0;
      mag        <= '0;
      n          <= '0;
      shift_left <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      data_out   <= '0;
      status_out <= ST_EXACT;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_reg <= op_in;
            busy   <= 1'b1;
            state  <= CLASSIFY;
          end
        end

        CLASSIFY: begin
          guard  <= 1'b0;
          sticky <= 1'b0;
          if (is_zero) begin
            data_out   <= '0;
            status_out <= ST_EXACT;
            done       <= 1'b1;
            state      <= DONE;
          end else if (is_overflow) begin
            data_out   <= sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            status_out <= is_min_int ? ST_EXACT : ST_OVERFLOW;
            done       <= 1'b1;
            state      <= DONE;
          end else if (is_underflow) begin
            data_out   <= '0;
            status_out <= ST_UNDERFLOW;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            mag        <= {5'd0, 1'b1, frac};
            n          <= shift_amt;
            shift_left <= shift_left_c;
            state      <= (shift_amt == 6'd0) ? SIGN : SHIFT;
          end
        end

        SHIFT: begin
          if (shift_left) begin
            mag <= {mag[29:0], 1'b0};
          end else begin
            mag    <= {1'b0, mag[30:1]};
            guard  <= mag[0];
            sticky <= sticky | guard;
          end
          n <= n - 6'd1;
          if (n == 6'd1) state <= SIGN;
        end

        SIGN: begin
          data_out <= result;
          // Only a nonzero input reaches here, so a zero magnitude means it rounded away.
          if (mag_rnd == 31'd0)  status_out <= ST_UNDERFLOW;
          else if (inexact)      status_out <= ST_INEXACT;
          else                   status_out <= ST_EXACT;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
